// File: rtl/dma_wr_data_split.sv
// -----------------------------------------------------------------------------
// dma_wr_data_split
//
// Purpose:
//   Re-slices one densely packed DMA write message (32-byte beats) into a
//   series of sub-request beat streams, one per length descriptor. Each
//   sub-request starts at byte 0 of its first output beat. Bytes left over
//   when a sub-request ends mid-beat are kept in a residual register and
//   lead the next sub-request of the same message.
//
// Optional feature:
//   `define WR_SPLIT_ERR_CHK_EN to get the sticky err output. It flags
//   zero-length descriptors, underrun (message ends before the sub-request is
//   complete) and overrun (last sub-request ends while message bytes remain).
//   On an overrun where the message has not reached msg_last, the remaining
//   message beats are drained. Without the macro there is no err port, no
//   drain, and an overrun residual is dropped silently.
//
// Ports:
//   dma_clk, rst_n                 clock, asynchronous active-low reset
//   desc_valid/len/last/ready      sub-request descriptor handshake
//   msg_valid/last/blen/data/ready packed message beat handshake
//   sub_valid/eop/last/blen/data   registered output beat
//   sub_ready                      downstream accept
//   err                            sticky mismatch flag (optional)
// -----------------------------------------------------------------------------
module dma_wr_data_split #(
  parameter int DATA_W = 256,
  parameter int BCNT   = DATA_W / 8,
  parameter int LEN_W  = 13
) (
  input  logic              dma_clk,
  input  logic              rst_n,
  input  logic              desc_valid,
  input  logic [LEN_W-1:0]  desc_len,
  input  logic              desc_last,
  output logic              desc_ready,
  input  logic              msg_valid,
  input  logic              msg_last,
  input  logic [LEN_W-1:0]  msg_blen,
  input  logic [DATA_W-1:0] msg_data,
  output logic              msg_ready,
  output logic              sub_valid,
  output logic              sub_eop,
  output logic              sub_last,
  output logic [LEN_W-1:0]  sub_blen,
  output logic [DATA_W-1:0] sub_data,
  input  logic              sub_ready
`ifdef WR_SPLIT_ERR_CHK_EN
  ,
  output logic              err
`endif
);

  localparam logic [LEN_W-1:0] BCNT_L = LEN_W'(BCNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SPLIT,
    ST_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              last_f_q, last_f_d;
  logic [LEN_W-1:0]  res_blen_q, res_blen_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  // Set once msg_last has been consumed; the residual may still hold bytes
  // of that message for following sub-requests.
  logic              msg_done_q, msg_done_d;

  logic              sub_valid_q, sub_eop_q, sub_last_q;
  logic [LEN_W-1:0]  sub_blen_q;
  logic [DATA_W-1:0] sub_data_q;

`ifdef WR_SPLIT_ERR_CHK_EN
  logic              err_q, err_d;
`endif

  // Datapath helpers
  logic              load_ok;
  logic [LEN_W-1:0]  need;
  logic [LEN_W-1:0]  sum_blen;
  logic [DATA_W-1:0] msg_mask;
  logic [DATA_W-1:0] emit_mask;
  logic [DATA_W-1:0] msg_clean;
  logic [2*DATA_W-1:0] comb_w;
  logic [DATA_W-1:0] comb_shift;
  logic [DATA_W-1:0] res_shift;

  // FSM outputs towards the output register
  logic              ld_en, ld_eop, ld_last;
  logic [LEN_W-1:0]  emit_n;
  logic [DATA_W-1:0] emit_src;
  logic              fin, adv, underrun, msg_done_nx;

  assign load_ok  = !sub_valid_q || sub_ready;
  assign need     = (rem_q > BCNT_L) ? BCNT_L : rem_q;
  assign sum_blen = res_blen_q + msg_blen;

  // Per-byte-lane keep masks: message lanes below msg_blen, output lanes
  // below the emitted count (so unused output bytes are zero).
  genvar gi;
  generate
    for (gi = 0; gi < BCNT; gi++) begin : g_lane
      assign msg_mask[gi*8 +: 8]  = (LEN_W'(gi) < msg_blen) ? 8'hFF : 8'h00;
      assign emit_mask[gi*8 +: 8] = (LEN_W'(gi) < emit_n)   ? 8'hFF : 8'h00;
    end
  endgenerate

  // Residual bytes sit at the bottom; the new beat is appended right above
  // them. Junk above msg_blen is masked so the residual stays zero-padded.
  always_comb begin
    msg_clean  = msg_data & msg_mask;
    comb_w     = {{DATA_W{1'b0}}, res_data_q} |
                 ({{DATA_W{1'b0}}, msg_clean} << {res_blen_q, 3'b000});
    comb_shift = DATA_W'(comb_w >> {need, 3'b000});
    res_shift  = res_data_q >> {need, 3'b000};
  end

  // Next-state / handshake logic
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    last_f_d    = last_f_q;
    res_blen_d  = res_blen_q;
    res_data_d  = res_data_q;
    msg_done_d  = msg_done_q;
    desc_ready  = 1'b0;
    msg_ready   = 1'b0;
    ld_en       = 1'b0;
    ld_eop      = 1'b0;
    ld_last     = 1'b0;
    emit_n      = '0;
    emit_src    = '0;
    fin         = 1'b0;
    adv         = 1'b0;
    underrun    = 1'b0;
    msg_done_nx = msg_done_q;
`ifdef WR_SPLIT_ERR_CHK_EN
    err_d       = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          if (desc_len == '0) begin
`ifdef WR_SPLIT_ERR_CHK_EN
            err_d = 1'b1;
`endif
          end else begin
            rem_d    = desc_len;
            last_f_d = desc_last;
            state_d  = ST_SPLIT;
          end
        end
      end

      ST_SPLIT: begin
        if (load_ok) begin
          if (res_blen_q >= need) begin
            // Residual alone covers this output beat.
            emit_n     = need;
            emit_src   = res_data_q;
            ld_en      = 1'b1;
            res_data_d = res_shift;
            res_blen_d = res_blen_q - need;
            fin        = (rem_q == need);
            adv        = 1'b1;
          end else if (msg_done_q) begin
            // Message already ended: flush what is left. With an empty
            // residual there is nothing to emit, only the termination.
            emit_n   = res_blen_q;
            emit_src = res_data_q;
            ld_en    = (res_blen_q != '0);
            ld_eop   = 1'b1;
            ld_last  = 1'b1;
            underrun = 1'b1;
          end else if (msg_valid) begin
            msg_ready = 1'b1;
            if (msg_last) begin
              msg_done_nx = 1'b1;
            end
            if (msg_last && (sum_blen <= need) && (sum_blen < rem_q)) begin
              // Final beat cannot finish the sub-request.
              emit_n   = sum_blen;
              emit_src = comb_w[DATA_W-1:0];
              ld_en    = 1'b1;
              ld_eop   = 1'b1;
              ld_last  = 1'b1;
              underrun = 1'b1;
            end else begin
              emit_n     = need;
              emit_src   = comb_w[DATA_W-1:0];
              ld_en      = 1'b1;
              res_data_d = comb_shift;
              res_blen_d = sum_blen - need;
              fin        = (rem_q == need);
              adv        = 1'b1;
            end
          end
        end

        if (underrun) begin
          res_data_d = '0;
          res_blen_d = '0;
          rem_d      = '0;
          msg_done_d = 1'b0;
          state_d    = ST_IDLE;
`ifdef WR_SPLIT_ERR_CHK_EN
          err_d      = 1'b1;
`endif
        end else if (adv) begin
          if (fin) begin
            ld_eop  = 1'b1;
            ld_last = last_f_q;
            rem_d   = '0;
            state_d = ST_IDLE;
            if (last_f_q) begin
`ifdef WR_SPLIT_ERR_CHK_EN
              if ((res_blen_d != '0) || !msg_done_nx) begin
                err_d = 1'b1;
              end
              if (!msg_done_nx) begin
                state_d = ST_DRAIN;
              end
`endif
              // The residual never carries into the next message.
              res_data_d = '0;
              res_blen_d = '0;
              msg_done_d = 1'b0;
            end else begin
              msg_done_d = msg_done_nx;
            end
          end else begin
            rem_d      = rem_q - need;
            msg_done_d = msg_done_nx;
          end
        end
      end

      ST_DRAIN: begin
        msg_ready = 1'b1;
        if (msg_valid && msg_last) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      last_f_q   <= 1'b0;
      res_blen_q <= '0;
      res_data_q <= '0;
      msg_done_q <= 1'b0;
`ifdef WR_SPLIT_ERR_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      last_f_q   <= last_f_d;
      res_blen_q <= res_blen_d;
      res_data_q <= res_data_d;
      msg_done_q <= msg_done_d;
`ifdef WR_SPLIT_ERR_CHK_EN
      err_q      <= err_d;
`endif
    end
  end

  // Single-stage output register; ld_en is only raised when it can load.
  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_valid_q <= 1'b0;
      sub_eop_q   <= 1'b0;
      sub_last_q  <= 1'b0;
      sub_blen_q  <= '0;
      sub_data_q  <= '0;
    end else if (ld_en) begin
      sub_valid_q <= 1'b1;
      sub_eop_q   <= ld_eop;
      sub_last_q  <= ld_last;
      sub_blen_q  <= emit_n;
      sub_data_q  <= emit_src & emit_mask;
    end else if (sub_ready) begin
      sub_valid_q <= 1'b0;
    end
  end

  assign sub_valid = sub_valid_q;
  assign sub_eop   = sub_eop_q;
  assign sub_last  = sub_last_q;
  assign sub_blen  = sub_blen_q;
  assign sub_data  = sub_data_q;
`ifdef WR_SPLIT_ERR_CHK_EN
  assign err       = err_q;
`endif

endmodule

// File: tb/tb_dma_wr_data_split.sv
// -----------------------------------------------------------------------------
// tb_dma_wr_data_split
//
// Scoreboard bench: each transfer's expected output beats are derived from the
// message bytes and descriptor lengths (plain byte slicing) and queued; a
// separate monitor pops and compares on every output handshake and checks
// that a stalled output beat holds still.
// -----------------------------------------------------------------------------
module tb_dma_wr_data_split;

  localparam int DATA_W = 256;
  localparam int BCNT   = 32;
  localparam int LEN_W  = 13;

  logic              dma_clk = 1'b0;
  logic              rst_n;
  logic              desc_valid;
  logic [LEN_W-1:0]  desc_len;
  logic              desc_last;
  logic              desc_ready;
  logic              msg_valid;
  logic              msg_last;
  logic [LEN_W-1:0]  msg_blen;
  logic [DATA_W-1:0] msg_data;
  logic              msg_ready;
  logic              sub_valid;
  logic              sub_eop;
  logic              sub_last;
  logic [LEN_W-1:0]  sub_blen;
  logic [DATA_W-1:0] sub_data;
  logic              sub_ready;
`ifdef WR_SPLIT_ERR_CHK_EN
  logic              err;
`endif

  always #5 dma_clk = ~dma_clk;

  dma_wr_data_split #(
    .DATA_W(DATA_W),
    .BCNT  (BCNT),
    .LEN_W (LEN_W)
  ) dut (
    .dma_clk   (dma_clk),
    .rst_n     (rst_n),
    .desc_valid(desc_valid),
    .desc_len  (desc_len),
    .desc_last (desc_last),
    .desc_ready(desc_ready),
    .msg_valid (msg_valid),
    .msg_last  (msg_last),
    .msg_blen  (msg_blen),
    .msg_data  (msg_data),
    .msg_ready (msg_ready),
    .sub_valid (sub_valid),
    .sub_eop   (sub_eop),
    .sub_last  (sub_last),
    .sub_blen  (sub_blen),
    .sub_data  (sub_data),
    .sub_ready (sub_ready)
`ifdef WR_SPLIT_ERR_CHK_EN
    ,
    .err       (err)
`endif
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  blen;
    logic              eop;
    logic              last;
  } beat_t;

  beat_t      exp_q[$];
  int         desc_lens[$];
  logic [7:0] msg_bytes[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         stall_mode = 1'b0;
  bit         rdy_rand   = 1'b0;
  bit         gaps       = 1'b0;

  function automatic logic [279:0] pack_beat(input beat_t b);
    return {9'd0, b.last, b.eop, b.blen, b.data};
  endfunction

  task automatic chk(input string name, input logic [279:0] act, input logic [279:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no handshake expected one within budget", name);
  endtask

  // Reference: cut the message bytes into consecutive sub-requests, each cut
  // into beats of up to BCNT bytes starting at byte 0.
  task automatic build_expected();
    int off;
    off = 0;
    for (int i = 0; i < desc_lens.size(); i++) begin
      for (int b = 0; b < desc_lens[i]; b += BCNT) begin
        beat_t e;
        int    n;
        n      = (desc_lens[i] - b > BCNT) ? BCNT : desc_lens[i] - b;
        e.data = '0;
        for (int k = 0; k < n; k++) e.data[8*k +: 8] = msg_bytes[off + b + k];
        e.blen = LEN_W'(n);
        e.eop  = (b + n == desc_lens[i]);
        e.last = e.eop && (i == desc_lens.size() - 1);
        exp_q.push_back(e);
      end
      off += desc_lens[i];
    end
  endtask

  task automatic make_bytes(input int nbytes);
    msg_bytes.delete();
    for (int i = 0; i < nbytes; i++) msg_bytes.push_back(8'($urandom));
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic wait_hs(input bit is_msg, output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    while (t < 5000) begin
      @(negedge dma_clk);
      if (is_msg ? msg_ready : desc_ready) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    @(posedge dma_clk);
    #1;
  endtask

  task automatic drive_descs();
    bit ok;
    for (int i = 0; i < desc_lens.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge dma_clk); #1; end
      desc_valid = 1'b1;
      desc_len   = LEN_W'(desc_lens[i]);
      desc_last  = (i == desc_lens.size() - 1);
      wait_hs(1'b0, ok);
      desc_valid = 1'b0;
      if (!ok) begin
        fail_timeout("desc_handshake");
        return;
      end
    end
  endtask

  task automatic drive_msg();
    int nb, nbeats, idx;
    bit ok;
    nb     = msg_bytes.size();
    nbeats = (nb + BCNT - 1) / BCNT;
    for (int j = 0; j < nbeats; j++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge dma_clk); #1; end
      for (int k = 0; k < BCNT; k++) begin
        idx = j * BCNT + k;
        msg_data[8*k +: 8] = (idx < nb) ? msg_bytes[idx] : 8'($urandom);
      end
      msg_blen  = LEN_W'((nb - j * BCNT > BCNT) ? BCNT : nb - j * BCNT);
      msg_last  = (j == nbeats - 1);
      msg_valid = 1'b1;
      wait_hs(1'b1, ok);
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      if (!ok) begin
        fail_timeout("msg_handshake");
        return;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 8000) begin
      @(negedge dma_clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      fail_timeout("output_drain");
      exp_q.delete();
    end
  endtask

  task automatic go_xfer();
    @(posedge dma_clk);
    #1;
    fork
      drive_descs();
      drive_msg();
    join
    wait_drain();
    @(negedge dma_clk);
    chk("idle_desc_ready", 280'(desc_ready), 280'(1));
  endtask

  task automatic run_xfer();
    int nbytes;
    nbytes = 0;
    foreach (desc_lens[i]) nbytes += desc_lens[i];
    make_bytes(nbytes);
    build_expected();
    go_xfer();
  endtask

  task automatic do_reset();
    @(posedge dma_clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge dma_clk);
    @(negedge dma_clk);
    rst_n = 1'b1;
  endtask

  // Downstream ready generator
  initial begin
    int sc;
    sc        = 0;
    sub_ready = 1'b1;
    forever begin
      @(posedge dma_clk);
      #1;
      if (!stall_mode) sc = 0;
      if (stall_mode && sc < 5 && sub_valid) begin
        sub_ready = 1'b0;
        sc++;
      end else if (rdy_rand) begin
        sub_ready = ($urandom_range(0, 3) != 0);
      end else begin
        sub_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    beat_t held, cur, e;
    bit    have_held;
    have_held = 1'b0;
    forever begin
      @(negedge dma_clk);
      if (!rst_n) begin
        have_held = 1'b0;
        continue;
      end
      cur.data = sub_data;
      cur.blen = sub_blen;
      cur.eop  = sub_eop;
      cur.last = sub_last;
      if (have_held) begin
        chk("hold_valid", 280'(sub_valid), 280'(1));
        chk("hold_stable", pack_beat(cur), pack_beat(held));
      end
      if (stall_mode && sub_valid && !sub_ready)
        chk("stall_msg_ready", 280'(msg_ready), 280'(0));
      if (sub_valid && sub_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", pack_beat(cur));
        end else begin
          e = exp_q.pop_front();
          chk("beat", pack_beat(cur), pack_beat(e));
        end
      end
      have_held = sub_valid && !sub_ready;
      held      = cur;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t e;
    bit    ok;
    rst_n      = 1'b0;
    desc_valid = 1'b0;
    desc_len   = '0;
    desc_last  = 1'b0;
    msg_valid  = 1'b0;
    msg_last   = 1'b0;
    msg_blen   = '0;
    msg_data   = '0;

    repeat (3) @(posedge dma_clk);
    @(negedge dma_clk);
    chk("rst_sub_valid",  280'(sub_valid),  280'(0));
    chk("rst_sub_eop",    280'(sub_eop),    280'(0));
    chk("rst_sub_last",   280'(sub_last),   280'(0));
    chk("rst_sub_blen",   280'(sub_blen),   280'(0));
    chk("rst_sub_data",   280'(sub_data),   280'(0));
    chk("rst_msg_ready",  280'(msg_ready),  280'(0));
    chk("rst_desc_ready", 280'(desc_ready), 280'(1));
`ifdef WR_SPLIT_ERR_CHK_EN
    chk("rst_err",        280'(err),        280'(0));
`endif
    rst_n = 1'b1;

    // Directed cases
    desc_lens = '{64};          run_xfer();
    desc_lens = '{40, 24};      run_xfer();
    desc_lens = '{10, 10, 12};  run_xfer();

    // Output back-pressure right after the first beat
    stall_mode = 1'b1;
    desc_lens  = '{96};
    run_xfer();
    stall_mode = 1'b0;

    // Randomised transfers with gaps and random back-pressure
    rdy_rand = 1'b1;
    gaps     = 1'b1;
    repeat (40) begin
      int nd;
      desc_lens.delete();
      nd = $urandom_range(1, 4);
      for (int i = 0; i < nd; i++)
        desc_lens.push_back(($urandom_range(0, 9) == 0) ? $urandom_range(1, 1024)
                                                         : $urandom_range(1, 160));
      run_xfer();
    end
    rdy_rand = 1'b0;
    gaps     = 1'b0;

    // Reset in the middle of a 3-beat sub-request
    make_bytes(32);
    e.data = '0;
    for (int k = 0; k < BCNT; k++) e.data[8*k +: 8] = msg_bytes[k];
    e.blen = LEN_W'(32);
    e.eop  = 1'b0;
    e.last = 1'b0;
    exp_q.push_back(e);
    @(posedge dma_clk);
    #1;
    desc_valid = 1'b1;
    desc_len   = LEN_W'(96);
    desc_last  = 1'b1;
    wait_hs(1'b0, ok);
    desc_valid = 1'b0;
    if (!ok) fail_timeout("rst_mid_desc");
    msg_data  = e.data;
    msg_blen  = LEN_W'(32);
    msg_last  = 1'b0;
    msg_valid = 1'b1;
    wait_hs(1'b1, ok);
    msg_valid = 1'b0;
    if (!ok) fail_timeout("rst_mid_msg");
    wait_drain();
    @(posedge dma_clk);
    #1;
    rst_n = 1'b0;
    @(negedge dma_clk);
    chk("rst_mid_sub_valid",  280'(sub_valid),  280'(0));
    chk("rst_mid_desc_ready", 280'(desc_ready), 280'(1));
    chk("rst_mid_msg_ready",  280'(msg_ready),  280'(0));
    rst_n = 1'b1;
    desc_lens = '{32};
    run_xfer();

    // Overrun: last sub-request ends with residual bytes left
    do_reset();
    desc_lens = '{16};
    make_bytes(32);
    build_expected();
    go_xfer();
`ifdef WR_SPLIT_ERR_CHK_EN
    chk("overrun_err", 280'(err), 280'(1));
`endif

    // Underrun: message ends 16 bytes short of the sub-request
    do_reset();
    desc_lens = '{48};
    make_bytes(32);
    e.data = '0;
    for (int k = 0; k < BCNT; k++) e.data[8*k +: 8] = msg_bytes[k];
    e.blen = LEN_W'(32);
    e.eop  = 1'b1;
    e.last = 1'b1;
    exp_q.push_back(e);
    go_xfer();
`ifdef WR_SPLIT_ERR_CHK_EN
    chk("underrun_err", 280'(err), 280'(1));
    repeat (3) @(negedge dma_clk);
    chk("underrun_err_sticky", 280'(err), 280'(1));

    // Zero-length descriptor is dropped and flagged
    do_reset();
    @(negedge dma_clk);
    chk("zero_len_err_clear", 280'(err), 280'(0));
    @(posedge dma_clk);
    #1;
    desc_valid = 1'b1;
    desc_len   = '0;
    desc_last  = 1'b1;
    wait_hs(1'b0, ok);
    desc_valid = 1'b0;
    if (!ok) fail_timeout("zero_len_desc");
    @(negedge dma_clk);
    chk("zero_len_err",        280'(err),        280'(1));
    chk("zero_len_desc_ready", 280'(desc_ready), 280'(1));
    chk("zero_len_no_output",  280'(sub_valid),  280'(0));
`endif

    repeat (2) @(negedge dma_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
